// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq; zero/carry exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 3
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   q;
  logic                 busy;
  logic                 done;
`ifdef ALU_SEQ_FLAGS_EN
  logic                 zero;
  logic                 carry;

  modport master (output start, op, a, b, input q, busy, done, zero, carry);
  modport slave  (input start, op, a, b, output q, busy, done, zero, carry);
`else
  modport master (output start, op, a, b, input q, busy, done);
  modport slave  (input start, op, a, b, output q, busy, done);
`endif
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops in EXEC, WIDTH-cycle shift-add multiply in MUL.
// Optional zero/carry flags enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq #(
  parameter int unsigned WIDTH = 3
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int unsigned QW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_e;

  state_e           r_state, w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_mplier;
  logic [QW-1:0]    r_q, r_acc, r_mcand;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_capture, w_mul_last;
  logic [QW-1:0]    w_ext_a, w_ext_b, w_res, w_prod;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_shamt;
`ifdef ALU_SEQ_FLAGS_EN
  logic             r_zero, r_carry;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_capture   = 1'b1;
        w_state_nxt = (op_e'(bus.op) == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC:  w_state_nxt = S_IDLE;
      S_MUL:   if (w_mul_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ext_a    = {{WIDTH{1'b0}}, r_a};
    w_ext_b    = {{WIDTH{1'b0}}, r_b};
    w_diff     = {1'b0, r_a} - {1'b0, r_b};
    w_shamt    = WIDTH'(r_b % WIDTH);
    w_mul_last = (r_cnt == CW'(WIDTH - 1));
    // Final product folds in the last partial term so q never sees a partial sum.
    w_prod     = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_res      = '0;
    case (r_op)
      OP_ADD:  w_res = w_ext_a + w_ext_b;
      OP_SUB:  w_res = {{(WIDTH-1){1'b0}}, w_diff};
      OP_AND:  w_res = w_ext_a & w_ext_b;
      OP_OR:   w_res = w_ext_a | w_ext_b;
      OP_XOR:  w_res = w_ext_a ^ w_ext_b;
      OP_SHL:  w_res = w_ext_a << w_shamt;
      OP_SHR:  w_res = w_ext_a >> w_shamt;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_done   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_op     <= op_e'(bus.op);
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_mplier <= bus.b;
        r_mcand  <= {{WIDTH{1'b0}}, bus.a};
        r_acc    <= '0;
        r_cnt    <= '0;
      end
      if (r_state == S_EXEC) begin
        r_q    <= w_res;
        r_done <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        r_zero  <= (w_res == '0);
        r_carry <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? w_res[WIDTH] : 1'b0;
`endif
      end
      if (r_state == S_MUL) begin
        r_acc    <= w_prod;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_mul_last) begin
          r_q    <= w_prod;
          r_done <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          r_zero  <= (w_prod == '0);
          r_carry <= 1'b0;
`endif
        end
      end
    end
  end

  assign bus.q    = r_q;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.zero  = r_zero;
  assign bus.carry = r_carry;
`endif
endmodule
